// File: rtl/accumulator_bank.sv
// accumulator_bank: NUM_CH parallel signed accumulators snapshotted into a FWFT FIFO.
// Build with ACC_SATURATE_EN to clamp lanes on overflow instead of wrapping.
module accumulator_bank #(
  parameter int WORD_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int NUM_CH     = 4,
  parameter int FIFO_CAP   = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           a_enable,
  input  logic                           clear,
  input  logic [NUM_CH*WORD_WIDTH-1:0]   d_in,
  input  logic                           w_enable,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [NUM_CH*ACC_WIDTH-1:0]    d_out,
  output logic                           full,
  output logic                           empty,
  output logic [PTR_WIDTH:0]             count,
  output logic [NUM_CH-1:0]              acc_ovf,
  output logic                           wr_drop
);
  logic signed [ACC_WIDTH-1:0] acc [NUM_CH];
  logic signed [ACC_WIDTH-1:0] ext [NUM_CH];
  logic signed [ACC_WIDTH-1:0] res [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH*ACC_WIDTH-1:0] acc_vec;
  logic [NUM_CH*ACC_WIDTH-1:0] mem [FIFO_CAP];
  logic [PTR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  assign full      = count == (PTR_WIDTH+1)'(FIFO_CAP);
  assign empty     = count == '0;
  assign out_valid = !empty;
  assign push      = w_enable && !full;
  assign pop       = out_valid && out_ready;
  assign d_out     = empty ? '0 : mem[rd_ptr];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic [ACC_WIDTH-1:0] sum;
    assign ext[i] = ACC_WIDTH'(signed'(d_in[i*WORD_WIDTH +: WORD_WIDTH]));
    assign sum = acc[i] + ext[i];
    // Overflow only possible when both operands share a sign and the result flips it
    assign ovf[i] = (acc[i][ACC_WIDTH-1] == ext[i][ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[i][ACC_WIDTH-1]);
`ifdef ACC_SATURATE_EN
    assign res[i] = !ovf[i] ? sum : acc[i][ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    assign res[i] = sum;
`endif
    assign acc_vec[i*ACC_WIDTH +: ACC_WIDTH] = acc[i];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      acc_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push) begin
          acc[i] <= (clear || !a_enable) ? '0 : ext[i];
          if (clear) acc_ovf[i] <= 1'b0;
        end else if (clear) begin
          acc[i]     <= '0;
          acc_ovf[i] <= 1'b0;
        end else if (a_enable) begin
          acc[i]     <= res[i];
          acc_ovf[i] <= acc_ovf[i] | ovf[i];
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      wr_drop <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
      if (w_enable && full) wr_drop <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= acc_vec;
  end
endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: scoreboard bench with an integer reference model of the lanes and FIFO.
module tb_accumulator_bank;
  localparam int W = 8, AW = 16, N = 4, CAP = 16, PW = 4;
  localparam int AMAX = 2**(AW-1) - 1, AMIN = -(2**(AW-1));
  logic clk = 0, reset_n = 0, a_enable = 0, clear = 0, w_enable = 0, out_ready = 0;
  logic [N*W-1:0] d_in = '0;
  logic out_valid, full, empty, wr_drop;
  logic [N*AW-1:0] d_out;
  logic [PW:0] count;
  logic [N-1:0] acc_ovf;
  accumulator_bank #(.WORD_WIDTH(W), .ACC_WIDTH(AW), .NUM_CH(N), .FIFO_CAP(CAP), .PTR_WIDTH(PW)) dut (
    .clk(clk), .reset_n(reset_n), .a_enable(a_enable), .clear(clear), .d_in(d_in),
    .w_enable(w_enable), .out_ready(out_ready), .out_valid(out_valid), .d_out(d_out),
    .full(full), .empty(empty), .count(count), .acc_ovf(acc_ovf), .wr_drop(wr_drop));
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  int macc [N];
  int count_m = 0;
  logic [N-1:0] ovf_m = '0;
  bit drop_m = 0;
  logic [N*AW-1:0] exp_q [$];
  logic [N*AW-1:0] held_val;
  bit held = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask
  function automatic logic [N*AW-1:0] snap();
    logic [N*AW-1:0] v;
    for (int i = 0; i < N; i++) v[i*AW +: AW] = AW'(macc[i]);
    return v;
  endfunction
  function automatic int lane(input logic [N*W-1:0] d, input int i);
    return int'($signed(d[i*W +: W]));
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) macc[i] = 0;
    count_m = 0;
    ovf_m = '0;
    drop_m = 0;
    exp_q.delete();
  endtask
  task automatic step(input bit ae, input bit clr, input bit we, input bit rdy, input logic [N*W-1:0] din);
    bit pop_m, push_m;
    int s;
    a_enable = ae; clear = clr; w_enable = we; out_ready = rdy; d_in = din;
    pop_m = count_m > 0 && rdy;
    push_m = we && count_m < CAP;
    if (we && !push_m) drop_m = 1;
    if (push_m) begin
      exp_q.push_back(snap());
      for (int i = 0; i < N; i++) macc[i] = (clr || !ae) ? 0 : lane(din, i);
      if (clr) ovf_m = '0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) macc[i] = 0;
      ovf_m = '0;
    end else if (ae) begin
      for (int i = 0; i < N; i++) begin
        s = macc[i] + lane(din, i);
        if (s > AMAX || s < AMIN) begin
          ovf_m[i] = 1'b1;
`ifdef ACC_SATURATE_EN
          s = s > 0 ? AMAX : AMIN;
`else
          s = s > AMAX ? s - 2**AW : s + 2**AW;
`endif
        end
        macc[i] = s;
      end
    end
    count_m = count_m + int'(push_m) - int'(pop_m);
    @(posedge clk);
    #1;
    chk("count", 64'(count), 64'(count_m));
    chk("full", 64'(full), 64'(count_m == CAP));
    chk("empty", 64'(empty), 64'(count_m == 0));
    chk("out_valid", 64'(out_valid), 64'(count_m != 0));
    chk("acc_ovf", 64'(acc_ovf), 64'(ovf_m));
    chk("wr_drop", 64'(wr_drop), 64'(drop_m));
  endtask
  task automatic check_reset_outputs();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_dout", 64'(d_out), 64'd0);
    chk("rst_ovf", 64'(acc_ovf), 64'd0);
    chk("rst_drop", 64'(wr_drop), 64'd0);
  endtask
  always @(negedge clk) begin
    if (!reset_n) held = 0;
    else begin
      if (held) chk("hold_stable", 64'(d_out), 64'(held_val));
      if (!out_valid) chk("dout_zero_when_empty", 64'(d_out), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 64'(d_out), 64'hdead);
        else chk("scoreboard_data", 64'(d_out), 64'(exp_q.pop_front()));
      end
      held = out_valid && !out_ready;
      held_val = d_out;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    model_reset();
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    step(1, 0, 0, 1, 32'd4);
    step(1, 0, 0, 1, 32'd3);
    step(1, 0, 0, 1, 32'd5);
    step(0, 0, 1, 1, 32'd0);
    repeat (2) step(0, 0, 0, 1, 32'd0);
    step(1, 0, 0, 1, 32'd10 << 16);
    step(1, 0, 1, 1, 32'd3 << 16);
    step(0, 0, 1, 1, 32'd0);
    repeat (3) step(0, 0, 0, 1, 32'd0);
    repeat (259) step(1, 0, 0, 1, 32'd127 << 8);
    step(0, 0, 1, 1, 32'd0);
    step(0, 0, 0, 1, 32'd0);
    step(1, 0, 0, 1, 32'h7f7f7f7f);
    step(0, 1, 0, 1, 32'd0);
    for (int k = 1; k <= 17; k++) step(1, 0, 1, 0, 32'(k));
    repeat (18) step(0, 0, 0, 1, 32'd0);
    for (int k = 0; k < 8; k++) step(1, 0, 1, 0, 32'h01020304 * (k + 1));
    for (int k = 0; k < 20; k++) step(1, 0, 1, 1, 32'(k * 37 + 5));
    repeat (10) step(0, 0, 0, 1, 32'd0);
    for (int k = 0; k < 5; k++) step(1, 0, 1, 0, 32'h11223344 + 32'(k));
    step(1, 0, 0, 0, 32'h05050505);
    #2 reset_n = 0;
    a_enable = 0; clear = 0; w_enable = 0; out_ready = 0; d_in = '0;
    model_reset();
    #1 check_reset_outputs();
    @(posedge clk);
    #1 reset_n = 1;
    step(1, 0, 0, 1, 32'd1);
    step(0, 0, 1, 1, 32'd0);
    repeat (2) step(0, 0, 0, 1, 32'd0);
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, $urandom);
    repeat (20) step(0, 0, 0, 1, 32'd0);
    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/accumulator_bank.md
# accumulator_bank

Multi-channel successor to the single-lane accumulator unit. It accumulates NUM_CH signed input lanes in parallel into ACC_WIDTH-wide accumulators. On command it snapshots all lanes into an internal FIFO and restarts accumulation. The FIFO drains through a valid/ready handshake. It sits at the south edge of the systolic array, collecting column partial sums and buffering finished results for the writeback path.

## Interface
- WORD_WIDTH, 8: width of each input lane, signed two's complement
- ACC_WIDTH, 16: width of each accumulator and output lane; must be ≥ WORD_WIDTH
- NUM_CH, 4: number of parallel lanes
- FIFO_CAP, 16: FIFO depth in snapshot entries; must equal 2**PTR_WIDTH
- PTR_WIDTH, 4: FIFO pointer width
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- a_enable  input  1  add d_in into the accumulators this cycle
- clear  input  1  zero the accumulators and acc_ovf
- d_in  input  NUM_CH*WORD_WIDTH  packed lanes; lane i at [i*WORD_WIDTH +: WORD_WIDTH]
- w_enable  input  1  snapshot the accumulators into the FIFO and restart
- out_ready  input  1  consumer accepts d_out
- out_valid  output  1  FIFO head is valid (equals !empty)
- d_out  output  NUM_CH*ACC_WIDTH  FIFO head; packed the same way as d_in
- full  output  1  FIFO holds FIFO_CAP entries
- empty  output  1  FIFO holds 0 entries
- count  output  PTR_WIDTH+1  current FIFO occupancy
- acc_ovf  output  NUM_CH  sticky per-lane signed-overflow flag
- wr_drop  output  1  sticky flag: a w_enable was refused because the FIFO was full

## Operation
- Lane operand: d_in lane i is sign-extended to ACC_WIDTH. Sum = acc[i] + sext(lane i), evaluated at ACC_WIDTH+1 bits.
- Overflow: set when the operands have equal signs and the result sign differs. It sets acc_ovf[i], which is cleared only by clear or reset.
- Priority within a cycle, accumulator side:
  1. Accepted push (w_enable && !full): the FIFO receives the pre-update accumulator vector. Each acc becomes sext(d_in) if a_enable, else 0. clear in the same cycle forces 0 and still pushes.
  2. clear without push: acc <= 0 and acc_ovf <= 0; a_enable is ignored.
  3. a_enable alone: acc <= the overflow-handled sum.
  4. Otherwise: acc holds.
- Refused push (w_enable && full): no FIFO write, wr_drop <= 1, and the accumulators act as if w_enable were 0. wr_drop is cleared only by reset.
- FIFO: circular, first-word-fall-through.
  - d_out = mem[rd_ptr] while out_valid; d_out = 0 while empty.
  - A pop occurs on out_valid && out_ready.
  - Pointers wrap modulo FIFO_CAP.
  - count increments on a push without a pop, decrements on a pop without a push, and holds when both or neither occur.
- full is evaluated on registered count. A push while full is refused even if a pop happens in the same cycle.
- The consumer may hold out_ready high continuously. d_out must stay stable while out_valid && !out_ready.

## Timing
- Reset values (asynchronous): acc = 0, rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, out_valid = 0, d_out = 0, acc_ovf = 0, wr_drop = 0. FIFO memory contents need not be reset.
- Reset asserted mid-operation discards all FIFO entries and accumulators immediately. No output may glitch high on the release edge.
- Accumulate latency: 1 cycle. acc reflects d_in after the rising edge on which a_enable is sampled.
- Push-to-visible latency: 1 cycle. out_valid rises the cycle after an accepted push into an empty FIFO, with d_out holding the snapshot.
- Pop throughput: 1 entry per cycle. Sustained push plus pop at count ≥ 1 keeps count constant.
- full, empty and count are registered. They update on the same edge as the pointer change.

## Configuration
- ACC_SATURATE_EN defined: on overflow, the lane clamps to 2**(ACC_WIDTH-1)-1 for positive overflow or -2**(ACC_WIDTH-1) for negative overflow, and acc_ovf[i] sets.
- ACC_SATURATE_EN undefined: on overflow, the lane wraps (two's complement truncation) and acc_ovf[i] still sets.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then lane 0 gets 4, 3, 5 with a_enable for 3 cycles, then w_enable for 1 cycle, out_ready = 1 -> next cycle out_valid = 1, d_out lane 0 = 12, other lanes = 0; following cycle empty = 1.
- Accumulate to lane 2 = 10, then w_enable && a_enable with lane 2 = 3 -> FIFO entry lane 2 = 10; acc lane 2 = 3; a second push yields 3.
- Lane 1 = 127 for 259 a_enable cycles (ACC_WIDTH = 16) -> acc_ovf[1] = 1. Lane 1 = -32643 without ACC_SATURATE_EN, 32767 with it. Only the next clear resets the flag.
- out_ready = 0, 17 pushes of distinct values -> full = 1 and count = 16 after the 16th; the 17th is refused and wr_drop = 1. Then out_ready = 1 -> 16 entries emerge in order, 1 per cycle, and empty = 1.
- FIFO at count = 8, push and pop asserted together for 20 cycles -> count stays 8, pointers wrap, and output order is preserved.
- Assert reset_n low mid-burst with count = 5 and a nonzero acc -> all outputs return to their reset values immediately. After release, a single push of lane 0 = 1 yields d_out lane 0 = 1.
